// File: rtl/image_ram_loader.sv
// image_ram_loader: buffers one raster frame, then serves window-slider reads.
// Optional build macro IMAGE_LOADER_BINARIZE_EN stores 1-bit thresholded pixels.
module image_ram_loader #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int IMAGE_ROW_LEN   = 32,
  parameter int IMAGE_COL_LEN   = 32,
  parameter int THRESHOLD       = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_last,
  input  logic [DATA_ADDR_WIDTH-1:0] ram_r_addr,
  input  logic                       ram_r_wen,
  output logic [DATA_WIDTH-1:0]      ram_r_data,
  output logic                       ws_start,
  input  logic                       core_done,
  output logic                       busy,
  output logic                       err,
  output logic [15:0]                frame_count
);

  localparam int NPIX  = IMAGE_ROW_LEN * IMAGE_COL_LEN;
  localparam int IW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] LAST = IW'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD,
    START,
    SERVE
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           wr_ptr_q, wr_ptr_d;
  logic                    err_q, err_d;
  logic [15:0]             fc_q, fc_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_pix;
  logic                    in_range;
  logic [IW-1:0]           rd_idx;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef IMAGE_LOADER_BINARIZE_EN
  assign wr_pix = {{(DATA_WIDTH-1){1'b0}},
                   (32'(s_data) >= 32'(THRESHOLD))};
`else
  logic unused_thr;
  assign unused_thr = ^32'(THRESHOLD);
  assign wr_pix     = s_data;
`endif

  assign in_range = {1'b0, ram_r_addr}
                    < (DATA_ADDR_WIDTH+1)'(NPIX);
  assign rd_idx   = ram_r_addr[IW-1:0];

  // Ready and status come straight from registered state.
  assign s_ready     = (state_q == LOAD);
  assign ws_start    = (state_q == START);
  assign busy        = (state_q != LOAD);
  assign err         = err_q;
  assign frame_count = fc_q;
  assign ram_r_data  = rdata_q;

  // Next-state logic: frame capture, framing checks, hand-off to core.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    err_d    = err_q;
    fc_d     = fc_q;
    wr_en    = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST) begin
            wr_ptr_d = '0;
            state_d  = START;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            wr_ptr_d = '0;
            err_d    = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + IW'(1);
          end
        end
      end
      START: state_d = SERVE;
      SERVE: begin
        if (core_done) begin
          state_d = LOAD;
          fc_d    = fc_q + 16'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      fc_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
      fc_q     <= fc_d;
    end
  end

  // Pixel store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= wr_pix;
  end

  // Registered read port, read-first against a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ram_r_wen) begin
      rdata_q <= in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_image_ram_loader.sv
// tb_image_ram_loader: directed checks of frame load, start, reads, errors.
// Read vectors are table driven; multi-cycle cases are hand sequences.
module tb_image_ram_loader;

  localparam int NPIX = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [10:0] ram_r_addr;
  logic        ram_r_wen;
  logic [7:0]  ram_r_data;
  logic        ws_start;
  logic        core_done;
  logic        busy;
  logic        err;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ws_cnt = 0;

  typedef struct {
    logic [10:0] addr;
    logic        wen;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t rv[12];

  image_ram_loader #(
    .DATA_WIDTH(8),
    .DATA_ADDR_WIDTH(11),
    .IMAGE_ROW_LEN(32),
    .IMAGE_COL_LEN(32),
    .THRESHOLD(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .ram_r_addr(ram_r_addr),
    .ram_r_wen(ram_r_wen),
    .ram_r_data(ram_r_data),
    .ws_start(ws_start),
    .core_done(core_done),
    .busy(busy),
    .err(err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ws_start) ws_cnt <= ws_cnt + 1;

  function automatic logic [7:0] px(input int v);
    logic [7:0] b;
    b = 8'(v);
`ifdef IMAGE_LOADER_BINARIZE_EN
    return {7'b0, (b >= 8'd128)};
`else
    return b;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_beats(input int n, input int base,
                            input int last_idx, input bit rd_chk,
                            input logic [7:0] rd_exp);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + base);
      s_last  = (i == last_idx);
      tick();
      if (i == 0 && rd_chk) begin
        check("read_first", 32'(ram_r_data), 32'(rd_exp));
        ram_r_wen = 1'b0;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_start(input int ws_before);
    check("ws_start_hi", 32'(ws_start), 1);
    check("busy_start", 32'(busy), 1);
    check("ready_start", 32'(s_ready), 0);
    tick();
    check("ws_start_lo", 32'(ws_start), 0);
    check("busy_serve", 32'(busy), 1);
    tick();
    check("ws_pulses", 32'(ws_cnt), 32'(ws_before + 1));
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    s_valid   = 1'b0;
  endtask

  initial begin
    int ws0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    ram_r_addr = '0; ram_r_wen = 1'b0; core_done = 1'b0;

    rv[0]  = '{11'd300,  1'b1, px(300)};
    rv[1]  = '{11'd0,    1'b1, px(0)};
    rv[2]  = '{11'd1023, 1'b1, px(1023)};
    rv[3]  = '{11'd1024, 1'b1, 8'd0};
    rv[4]  = '{11'd7,    1'b0, 8'd0};
    rv[5]  = '{11'd2047, 1'b1, 8'd0};
    rv[6]  = '{11'd1,    1'b1, px(1)};
    rv[7]  = '{11'd5,    1'b0, px(1)};
    rv[8]  = '{11'd127,  1'b1, px(127)};
    rv[9]  = '{11'd128,  1'b1, px(128)};
    rv[10] = '{11'd255,  1'b1, px(255)};
    rv[11] = '{11'd3,    1'b1, px(3)};

    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(s_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ws", 32'(ws_start), 0);
    check("rst_err", 32'(err), 0);
    check("rst_fc", 32'(frame_count), 0);
    check("rst_rdata", 32'(ram_r_data), 0);

    // Raw frame, data = addr[7:0].
    ws0 = ws_cnt;
    send_beats(NPIX, 0, NPIX - 1, 1'b0, 8'd0);
    check_start(ws0);
    check("frame_err", 32'(err), 0);

    // Reads during SERVE with stalled producer.
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int k = 0; k < 12; k++) begin
      ram_r_addr = rv[k].addr;
      ram_r_wen  = rv[k].wen;
      tick();
      check($sformatf("rd_vec%0d", k), 32'(ram_r_data), 32'(rv[k].exp));
    end
    check("bp_ready", 32'(s_ready), 0);
    ram_r_addr = 11'd4;
    ram_r_wen  = 1'b1;
    tick();
    check("bp_nowrite", 32'(ram_r_data), 32'(px(4)));
    ram_r_wen = 1'b0;

    pulse_done();
    check("done_ready", 32'(s_ready), 1);
    check("done_busy", 32'(busy), 0);
    check("done_fc", 32'(frame_count), 1);

    // Early s_last discards the frame.
    ws0 = ws_cnt;
    send_beats(11, 100, 10, 1'b0, 8'd0);
    tick();
    check("early_err", 32'(err), 1);
    check("early_ready", 32'(s_ready), 1);
    check("early_nows", 32'(ws_cnt), 32'(ws0));

    ws0 = ws_cnt;
    send_beats(NPIX, 7, NPIX - 1, 1'b0, 8'd0);
    check_start(ws0);
    check("err_sticky", 32'(err), 1);
    ram_r_addr = 11'd300; ram_r_wen = 1'b1;
    tick();
    check("rd_f2_300", 32'(ram_r_data), 32'(px(307)));
    ram_r_addr = 11'd5;
    tick();
    check("rd_f2_5", 32'(ram_r_data), 32'(px(12)));
    ram_r_wen = 1'b0;
    pulse_done();
    check("done_fc2", 32'(frame_count), 2);

    // core_done outside SERVE is ignored.
    pulse_done();
    check("idle_done_fc", 32'(frame_count), 2);
    check("idle_done_busy", 32'(busy), 0);

    // Reset mid-frame.
    send_beats(500, 200, -1, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst_ready", 32'(s_ready), 1);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_fc", 32'(frame_count), 0);

    // Full frame without s_last; same-address read-first on beat 0.
    ws0 = ws_cnt;
    ram_r_addr = 11'd0; ram_r_wen = 1'b1;
    send_beats(NPIX, 50, -1, 1'b1, px(200));
    check_start(ws0);
    check("nolast_err", 32'(err), 1);
    ram_r_addr = 11'd0; ram_r_wen = 1'b1;
    tick();
    check("rd_f3_0", 32'(ram_r_data), 32'(px(50)));
    ram_r_addr = 11'd600;
    tick();
    check("rd_f3_600", 32'(ram_r_data), 32'(px(650)));
    ram_r_wen = 1'b0;
    pulse_done();
    check("done_fc3", 32'(frame_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_ram_loader.md
# image_ram_loader

- Producer end of the window-slider image-RAM read interface.
- Accepts a raster pixel stream over a valid/ready handshake and stores one IMAGE_ROW_LEN×IMAGE_COL_LEN frame in internal RAM.
- Once a full frame is stored, pulses `ws_start`, then answers `ram_r_addr`/`ram_r_wen` reads from the neural core's window slider with 1-cycle latency.
- Releases the buffer for the next frame when the core signals frame completion.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `DATA_ADDR_WIDTH`, 10, RAM address width; NPIX = IMAGE_ROW_LEN*IMAGE_COL_LEN must be ≤ 2**DATA_ADDR_WIDTH.
- `IMAGE_ROW_LEN`, 32, pixels per row.
- `IMAGE_COL_LEN`, 32, rows per frame.
- `THRESHOLD`, 128, binarize threshold; used only with the macro.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `s_valid`  in  1  pixel beat valid.
- `s_ready`  out  1  loader can accept a beat.
- `s_data`  in  DATA_WIDTH  pixel, raster order.
- `s_last`  in  1  marks the final pixel of a frame.
- `ram_r_addr`  in  DATA_ADDR_WIDTH  read address from the window slider.
- `ram_r_wen`  in  1  read enable from the window slider.
- `ram_r_data`  out  DATA_WIDTH  read data.
- `ws_start`  out  1  one-cycle pulse: frame ready.
- `core_done`  in  1  one-cycle pulse: core finished the frame.
- `busy`  out  1  high in START and SERVE.
- `err`  out  1  sticky framing error.
- `frame_count`  out  16  completed frames, wraps at 0xFFFF→0.

## Operation
- States: LOAD, START, SERVE. Reset state is LOAD.
- LOAD:
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) writes `mem[wr_ptr]` and increments `wr_ptr`.
  - Beat at `wr_ptr`==NPIX-1 → START and `wr_ptr`←0.
  - If `s_last` is absent on that beat, set `err`; the frame is still accepted.
  - `s_last` on a beat with `wr_ptr`<NPIX-1: that beat is written, `err` set, `wr_ptr`←0, stay in LOAD (frame discarded).
- START:
  - `s_ready`=0, `ws_start`=1 for exactly this cycle.
  - Unconditionally → SERVE.
- SERVE:
  - `s_ready`=0; reads are served.
  - `core_done`=1 → LOAD and `frame_count` increments.
  - `core_done` in LOAD or START is ignored.
- Reads:
  - Served in every state.
  - `ram_r_wen`=1 registers `mem[ram_r_addr]` onto `ram_r_data`.
  - Address ≥ NPIX returns 0.
  - `ram_r_wen`=0 holds the previous `ram_r_data`.
- Same-address read and write in the same cycle (LOAD only) returns old data (read-first).
- `err` clears only on `rst`.
- Reset:
  - All outputs → 0; `s_ready` → 1 on the first cycle after reset.
  - `wr_ptr`, state and counters are cleared.
  - Memory contents are not cleared.
  - Reset mid-frame discards the partial frame.

## Timing
- Read latency: 1 cycle. Address at edge N → data valid after edge N+1.
- Final pixel accepted at edge N → `ws_start` high during cycle N+1 → `busy` high from cycle N+1.
- `core_done` at edge M → `s_ready`=1 and `busy`=0 in cycle M+1; a new beat is accepted at edge M+1.
- Sustained throughput: 1 pixel/cycle in LOAD. Minimum frame period is NPIX+2 cycles plus core time.
- `s_ready` depends only on state (registered), never on `s_valid`.

## Configuration
- `IMAGE_LOADER_BINARIZE_EN` defined:
  - Each stored pixel is `{DATA_WIDTH-1 zeros, (s_data ≥ THRESHOLD)}`.
  - Reads therefore return 0 or 1.
- Not defined: `s_data` is stored verbatim and `THRESHOLD` is unused.

## Test plan
- Raw frame: stream 1024 beats `s_data`=addr[7:0], `s_last` on beat 1023 → one `ws_start` pulse one cycle later; read addr 300 returns 0x2C next cycle; `err`=0.
- Early `s_last` on beat 10 → `err`=1, no `ws_start`; the following full 1024-beat frame still produces `ws_start`.
- Backpressure: `s_valid` held high during SERVE → `s_ready`=0, no writes; `core_done` pulse → `s_ready`=1 next cycle, `frame_count`=1.
- Out-of-range read addr 1023+1 with NPIX=1024, `DATA_ADDR_WIDTH`=11 → `ram_r_data`=0; `ram_r_wen`=0 holds the prior value.
- Reset after 500 beats → `s_ready`=1, `wr_ptr` restarts; the next full frame gives `ws_start`, and reads show the new data.
- `IMAGE_LOADER_BINARIZE_EN` with `THRESHOLD`=128: pixels 127, 128, 255 → reads 0, 1, 1.
